// File: rtl/conv_line_ctrl.sv
// Line-buffer sequencer for the 5-tap BRAM delay in the HDMI convolution path.
// Drives the shared address/strobes and aligns row/column flags with stat_o.
module conv_line_ctrl #(
   parameter int ADDR_W = 11,
   parameter int LAT    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        stat_in,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   output logic              bram_we,
   output logic [4:0]        row_mask,
   output logic              col_first,
   output logic              col_last,
   output logic [2:0]        stat_o,
   output logic [ADDR_W:0]   line_len,
   output logic              ovf
);

   typedef enum logic [1:0] {
      WAIT_VS,
      WAIT_DE,
      ACTIVE
   } state_e;

   localparam logic [ADDR_W:0]   FULL    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] ROW_MAX = '1;

   state_e            st_q, st_d;
   logic              vs_q;
   logic [ADDR_W:0]   pix_q, pix_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              ovf_q, ovf_d;
   logic [4:0]        rm_q, rm_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              en_q, en_d;
   logic [9:0]        pipe_q [LAT];
   logic [9:0]        pipe_d;

   logic              de, vs_rise, start, pixel, cont, over, eol;
   logic              first, last;
   logic [ADDR_W:0]   col;
   logic [ADDR_W-1:0] row_cur;
   logic [4:0]        mask_new;

   assign de      = stat_in[0];
   assign vs_rise = stat_in[2] & ~vs_q;
   assign start   = de & (vs_rise | (st_q == WAIT_DE));
   assign pixel   = de & (start | (st_q == ACTIVE));
   assign cont    = pixel & ~start;
   assign col     = start ? '0 : pix_q;
   // pix_q parks at FULL once the line is too long for the buffer
   assign over    = cont & (pix_q == FULL);
   assign eol     = (st_q == ACTIVE) & ~de;
   assign row_cur = vs_rise ? '0 : row_q;
   assign first   = pixel & (col == '0);
   assign last    = pixel & (len_q != '0) & (col == len_q - 1'b1);

   always_comb begin
      mask_new = '0;
      for (int i = 0; i < 5; i++) begin
         mask_new[i] = (int'(row_cur) >= i);
      end
   end

   always_comb begin
      st_d  = st_q;
      pix_d = pix_q;
      row_d = row_q;
      len_d = len_q;
      ovf_d = ovf_q;
      rm_d  = rm_q;
      if (eol) begin
         len_d = pix_q;
         if (row_q != ROW_MAX) begin
            row_d = row_q + 1'b1;
         end
         st_d = WAIT_DE;
      end
      if (vs_rise) begin
         st_d  = WAIT_DE;
         row_d = '0;
         ovf_d = 1'b0;
         rm_d  = '0;
      end
      if (start) begin
         st_d  = ACTIVE;
         pix_d = {{ADDR_W{1'b0}}, 1'b1};
         rm_d  = mask_new;
      end else if (cont) begin
         if (over) begin
            ovf_d = 1'b1;
         end else begin
            pix_d = pix_q + 1'b1;
         end
      end
   end

   always_comb begin
      addr_d = '0;
      en_d   = 1'b0;
      if (pixel) begin
         addr_d = over ? '1 : col[ADDR_W-1:0];
         en_d   = ~over;
      end
      pipe_d = {stat_in, rm_d, first, last};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q   <= WAIT_VS;
         vs_q   <= 1'b0;
         pix_q  <= '0;
         row_q  <= '0;
         len_q  <= '0;
         ovf_q  <= 1'b0;
         rm_q   <= '0;
         addr_q <= '0;
         en_q   <= 1'b0;
         for (int i = 0; i < LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         st_q   <= st_d;
         vs_q   <= stat_in[2];
         pix_q  <= pix_d;
         row_q  <= row_d;
         len_q  <= len_d;
         ovf_q  <= ovf_d;
         rm_q   <= rm_d;
         addr_q <= addr_d;
         en_q   <= en_d;
         pipe_q[0] <= pipe_d;
         for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign bram_addr = addr_q;
   assign bram_en   = en_q;
   assign bram_we   = en_q;
   assign line_len  = len_q;
   assign ovf       = ovf_q;
   assign {stat_o, row_mask, col_first, col_last} = pipe_q[LAT-1];

endmodule

// File: tb/tb_conv_line_ctrl.sv
// Bench for conv_line_ctrl: reference model feeds a scoreboard of aligned
// tap flags; a narrow ADDR_W=3 instance covers the overflow path.
module tb_conv_line_ctrl;

   localparam int AW    = 11;
   localparam int LATC  = 3;
   localparam int CAP   = 2**AW;
   localparam int ROWMX = 2**AW - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [2:0]    stat_in = '0;

   logic [AW-1:0] bram_addr;
   logic          bram_en, bram_we, col_first, col_last, ovf;
   logic [4:0]    row_mask;
   logic [2:0]    stat_o;
   logic [AW:0]   line_len;

   logic [2:0]    d1_addr;
   logic          d1_en, d1_we, d1_first, d1_last, d1_ovf;
   logic [4:0]    d1_mask;
   logic [2:0]    d1_stat;
   logic [3:0]    d1_len;

   int total = 0;
   int bad   = 0;

   logic [9:0] sb [$];

   bit         m_vs, m_armed, m_in, m_ovf;
   int         m_px, m_row, m_len;
   logic [4:0] m_mask;
   int         e_addr;
   bit         e_en, e_first, e_last;

   always #5 clk = ~clk;

   conv_line_ctrl #(.ADDR_W(AW), .LAT(LATC)) dut (
      .clk(clk), .rst(rst), .stat_in(stat_in),
      .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
      .row_mask(row_mask), .col_first(col_first), .col_last(col_last),
      .stat_o(stat_o), .line_len(line_len), .ovf(ovf)
   );

   conv_line_ctrl #(.ADDR_W(3), .LAT(LATC)) dut3 (
      .clk(clk), .rst(rst), .stat_in(stat_in),
      .bram_addr(d1_addr), .bram_en(d1_en), .bram_we(d1_we),
      .row_mask(d1_mask), .col_first(d1_first), .col_last(d1_last),
      .stat_o(d1_stat), .line_len(d1_len), .ovf(d1_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_vs = 0; m_armed = 0; m_in = 0; m_ovf = 0;
      m_px = 0; m_row = 0; m_len = 0; m_mask = '0;
   endtask

   task automatic model_step(input logic [2:0] s);
      bit vr, de;
      int col;
      vr   = s[2] && !m_vs;
      de   = s[0];
      m_vs = s[2];
      e_addr = 0; e_en = 0; e_first = 0; e_last = 0;
      if (m_in && !de) begin
         m_len = m_px;
         if (m_row < ROWMX) m_row++;
         m_in = 0;
      end
      if (vr) begin
         m_armed = 1; m_row = 0; m_ovf = 0; m_mask = '0; m_in = 0;
      end
      if (m_armed && de) begin
         if (!m_in) begin
            m_in = 1;
            m_px = 0;
            for (int i = 0; i < 5; i++) m_mask[i] = (m_row >= i);
         end
         col = m_px;
         if (col < CAP) begin
            e_addr = col;
            e_en   = 1;
            m_px++;
         end else begin
            e_addr = CAP - 1;
            m_ovf  = 1;
         end
         e_first = (col == 0);
         e_last  = (m_len != 0) && (col == m_len - 1);
      end
      sb.push_back({s, m_mask, e_first, e_last});
   endtask

   task automatic step(input logic [2:0] s);
      logic [9:0] pe;
      stat_in = s;
      model_step(s);
      @(posedge clk);
      #1;
      chk("addr", bram_addr, e_addr);
      chk("en", bram_en, e_en);
      chk("we", bram_we, e_en);
      chk("line_len", line_len, m_len);
      chk("ovf", ovf, m_ovf);
      pe = sb.pop_front();
      chk("stat_o", stat_o, pe[9:7]);
      chk("row_mask", row_mask, pe[6:2]);
      chk("col_first", col_first, pe[1]);
      chk("col_last", col_last, pe[0]);
   endtask

   task automatic do_reset(input logic [2:0] s);
      rst     = 1'b0;
      stat_in = s;
      @(posedge clk);
      #1;
      chk("rst_addr", bram_addr, 0);
      chk("rst_en", bram_en, 0);
      chk("rst_we", bram_we, 0);
      chk("rst_mask", row_mask, 0);
      chk("rst_first", col_first, 0);
      chk("rst_last", col_last, 0);
      chk("rst_stat", stat_o, 0);
      chk("rst_len", line_len, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_d1_ovf", d1_ovf, 0);
      model_reset();
      sb.delete();
      for (int i = 0; i < LATC - 1; i++) sb.push_back('0);
      rst = 1'b1;
   endtask

   task automatic line(input int n, input int gap);
      for (int i = 0; i < n; i++) step(3'b001);
      for (int i = 0; i < gap; i++) step(i == 0 ? 3'b010 : 3'b000);
   endtask

   task automatic vsync();
      step(3'b100);
      step(3'b100);
      step(3'b000);
   endtask

   initial begin
      do_reset(3'b000);
      step(3'b000);

      // de activity before any vsync
      line(8, 4);
      line(5, 2);

      // three 8-pixel lines
      vsync();
      for (int i = 0; i < 8; i++) step(3'b001);
      step(3'b000);
      chk("len_after_l1", line_len, 8);
      step(3'b000); step(3'b000); step(3'b000);
      line(8, 4);
      line(8, 4);

      // random status pattern
      for (int i = 0; i < 200; i++) step(3'($urandom_range(0, 7)));
      step(3'b000);

      // two frames of six lines; frame 2 opens with vsync+de together
      vsync();
      for (int l = 0; l < 6; l++) line(8, 3);
      step(3'b101);
      for (int i = 0; i < 7; i++) step(3'b001);
      step(3'b000);
      for (int l = 0; l < 5; l++) line(8, 1);
      step(3'b000);

      // line longer than the narrow instance can buffer
      step(3'b100);
      chk("d1_ovf_clr0", d1_ovf, 0);
      step(3'b000);
      for (int k = 0; k < 10; k++) begin
         step(3'b001);
         chk($sformatf("d1_we_%0d", k), d1_we, k < 8);
         chk($sformatf("d1_ovf_%0d", k), d1_ovf, k >= 8);
         if (k < 8) chk($sformatf("d1_addr_%0d", k), d1_addr, k);
      end
      step(3'b000);
      chk("d1_len", d1_len, 8);
      chk("len10", line_len, 10);
      step(3'b000);
      step(3'b100);
      chk("d1_ovf_clr1", d1_ovf, 0);
      step(3'b000);

      // reset in the middle of a line
      line(8, 2);
      for (int i = 0; i < 4; i++) step(3'b001);
      do_reset(3'b001);
      for (int i = 0; i < 5; i++) step(3'b001);
      line(6, 2);
      vsync();
      line(8, 4);
      line(8, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv_line_ctrl.md
# conv_line_ctrl

Sequencer for the five-tap line-buffer delay (`bram_delay`) in the HDMI convolution filter path. Decodes the incoming video status (vsync, hsync, data-enable) and generates the shared BRAM address, write and enable strobes for the line buffers. Tracks column and row position, measures the active line length, and produces per-tap row-valid masks and column-edge flags. The downstream 5x5 kernel uses these to handle image borders; `stat_o` is delayed to stay aligned with the tap outputs.

## Interface
- `ADDR_W`, 11, width of the line-buffer address; maximum line length is 2^ADDR_W pixels.
- `LAT`, 3, cycles from `stat_in` to `stat_o`/`row_mask`/`col_first`/`col_last`; legal range 1..8.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `stat_in`  in  3  video status: [2] vsync, [1] hsync, [0] de; active-high.
- `bram_addr`  out  ADDR_W  shared read/write address for all line buffers.
- `bram_en`  out  1  line-buffer enable (read-before-write).
- `bram_we`  out  1  line-buffer write strobe.
- `row_mask`  out  5  bit i = tap i (pa..pe) holds a valid image row of the current frame.
- `col_first`  out  1  aligned pixel is column 0.
- `col_last`  out  1  aligned pixel is column `line_len`-1.
- `stat_o`  out  3  `stat_in` delayed by LAT cycles.
- `line_len`  out  ADDR_W+1  active pixels in the last completed line.
- `ovf`  out  1  sticky: a line exceeded 2^ADDR_W pixels in the current frame.

## Operation
- States:
  - WAIT_VS: after reset, ignore de until the vsync rising edge.
  - WAIT_DE: between lines.
  - ACTIVE: de high.
- Transitions:
  - Vsync rising edge, any state -> WAIT_DE; clears `row_cnt`, `col_cnt` and `ovf`.
  - WAIT_DE, de=1 -> ACTIVE.
  - ACTIVE, de=0 -> WAIT_DE.
- `col_cnt`:
  - Zero on entry to ACTIVE; +1 per de-high cycle.
  - Saturates at 2^ADDR_W-1. On an attempt to go past that, set `ovf` and drop `bram_we` for the rest of the line.
- End of line (de falling edge):
  - `line_len` <= pixels counted (saturated at 2^ADDR_W).
  - `row_cnt` +1, saturating at 2^(ADDR_W)-1.
- `line_len` is retained across frames; reset value 0.
- Address and strobes:
  - `bram_addr` = `col_cnt`.
  - `bram_en` = `bram_we` = de while in ACTIVE (subject to overflow gating).
  - Outside ACTIVE, `bram_addr` holds 0.
- `row_mask[i]` = (`row_cnt` >= i), sampled at line start and held for the whole line. First line of a frame gives 5'b00001; fifth and later lines give 5'b11111.
- `col_first`: de at column 0.
- `col_last`: de at `col_cnt` == `line_len`-1. Never asserts while `line_len` is 0.
- `hsync` is only passed through `stat_o`.
- Vsync and de rising in the same cycle: the frame clear wins, and that pixel is column 0 of row 0.
- Reset mid-line: all state is discarded; the block returns to WAIT_VS.

## Timing
- Reset values:
  - `bram_addr`=0, `bram_en`=0, `bram_we`=0.
  - `row_mask`=0, `col_first`=0, `col_last`=0.
  - `stat_o`=0, `line_len`=0, `ovf`=0.
  - Delay pipeline cleared.
- `bram_addr`/`bram_en`/`bram_we` are registered: valid one cycle after the `stat_in` sample they describe.
- `stat_o`, `row_mask`, `col_first` and `col_last` form one LAT-deep shift pipeline, mutually aligned. They are valid LAT cycles after the corresponding `stat_in`.
- `line_len` updates one cycle after the de falling edge. `ovf` sets one cycle after the overflowing sample.
- Back-to-back lines with a one-cycle de gap are supported: the row increment and the next line start do not collide.

## Test plan
- Reset, then de pulses without vsync -> `bram_we` stays 0 and `row_mask` stays 0.
- Vsync, then three lines of 8 pixels, 4-cycle blanking:
  - `bram_addr` runs 0..7 each line.
  - `line_len`=8 after line 1.
  - `row_mask` = 00001, 00011, 00111 on lines 1-3.
- LAT=3, random `stat_in` pattern -> `stat_o` equals `stat_in` delayed exactly 3 cycles.
- Frame with 6 lines of 8 pixels, second frame:
  - `col_first` on column 0 and `col_last` on column 7 in both frames, including line 1 of frame 2.
  - `row_mask` resets to 00001 in frame 2.
- ADDR_W=3, 10-pixel line:
  - `ovf` rises after pixel 8 and `bram_we` drops for the rest of the line.
  - `line_len`=8.
  - Next vsync clears `ovf`.
- `rst` low for 1 cycle mid-line:
  - All outputs return to reset values.
  - De ignored until the next vsync rising edge.
